// File: rtl/python_align_pkg.sv
// Shared definitions for the PYTHON LVDS word-alignment sequencer.
package python_align_pkg;

    localparam int STATE_BITS = 3;

    typedef enum logic [STATE_BITS-1:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    // Width of a counter that must hold 0..max_retry; never narrower than one bit.
    function automatic int retry_width(input int max_retry);
        return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/python_align_ctrl.sv
// Sequencer for the PYTHON LVDS word aligner: pulses the aligner reset, waits
// for a done/error verdict with a timeout, retries a bounded number of times,
// and watches for loss of lock once aligned.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | aligner held in reset, waiting for start
// RESET  | aligner held in reset for RESET_CYCLES cycles
// WAIT   | aligner released, waiting for done/error or timeout
// LOCKED | aligner reports done; a falling done means lock loss
// FAIL   | retries exhausted; aligner held in reset until start/stop
module python_align_ctrl
    import python_align_pkg::*;
#(
    parameter int RESET_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRY      = 7,
    parameter int AUTO_RELOCK    = 1
) (
    input  logic                                reset,
    input  logic                                clk,
    input  logic                                start,
    input  logic                                stop,
    output logic                                align_reset,
    input  logic                                align_done,
    input  logic                                align_error,
    output logic                                busy,
    output logic                                locked,
    output logic                                failed,
    output logic                                lock_lost,
    output logic [retry_width(MAX_RETRY)-1:0]   retry_count,
    output logic [STATE_BITS-1:0]               state
);

    localparam int RW = retry_width(MAX_RETRY);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int CW = $clog2(RESET_CYCLES + 1);

    localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    state_t          state_q, state_d;
    logic [CW-1:0]   rst_timer_q, rst_timer_d;
    logic [TW-1:0]   wait_timer_q, wait_timer_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            lost_q, lost_d;
    logic            align_reset_q, busy_q, locked_q, failed_q;
    logic            attempt_fail;

    // Next-state, timer and status computation; timers fall back to zero so
    // any state change clears them.
    always_comb begin
        state_d      = state_q;
        rst_timer_d  = '0;
        wait_timer_d = '0;
        retry_d      = retry_q;
        lost_d       = lost_q;
        attempt_fail = 1'b0;

        case (state_q)
            ST_IDLE: begin
            end
            ST_RESET: begin
                if (rst_timer_q == RESET_LAST) begin
                    state_d = ST_WAIT;
                end else begin
                    rst_timer_d = rst_timer_q + CW'(1);
                end
            end
            ST_WAIT: begin
                // Error wins when done and error arrive together.
                if (align_error) begin
                    attempt_fail = 1'b1;
                end else if (align_done) begin
                    state_d = ST_LOCKED;
                end else if (wait_timer_q == WAIT_LAST) begin
                    attempt_fail = 1'b1;
                end else begin
                    wait_timer_d = wait_timer_q + TW'(1);
                end
            end
            ST_LOCKED: begin
                if (!align_done) begin
                    lost_d = 1'b1;
                    if (AUTO_RELOCK != 0) begin
                        state_d = ST_RESET;
                        retry_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FAIL: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Retry counter saturates: the last allowed failure goes to FAIL.
        if (attempt_fail) begin
            if (retry_q == RETRY_MAX) begin
                state_d = ST_FAIL;
            end else begin
                retry_d = retry_q + RW'(1);
                state_d = ST_RESET;
            end
        end

        // Software control overrides everything; stop beats start.
        if (stop) begin
            state_d      = ST_IDLE;
            rst_timer_d  = '0;
            wait_timer_d = '0;
            retry_d      = retry_q;
            lost_d       = lost_q;
        end else if (start) begin
            state_d      = ST_RESET;
            rst_timer_d  = '0;
            wait_timer_d = '0;
            retry_d      = '0;
            lost_d       = 1'b0;
        end
    end

    // State, timers and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rst_timer_q   <= '0;
            wait_timer_q  <= '0;
            retry_q       <= '0;
            lost_q        <= 1'b0;
            align_reset_q <= 1'b1;
            busy_q        <= 1'b0;
            locked_q      <= 1'b0;
            failed_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_timer_q   <= rst_timer_d;
            wait_timer_q  <= wait_timer_d;
            retry_q       <= retry_d;
            lost_q        <= lost_d;
            align_reset_q <= (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAIL);
            busy_q        <= (state_d == ST_RESET) || (state_d == ST_WAIT);
            locked_q      <= (state_d == ST_LOCKED);
            failed_q      <= (state_d == ST_FAIL);
        end
    end

    assign align_reset = align_reset_q;
    assign busy        = busy_q;
    assign locked      = locked_q;
    assign failed      = failed_q;
    assign lock_lost   = lost_q;
    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_python_align_ctrl.sv
// Bench for python_align_ctrl: two instances (auto-relock on and off) share
// stimulus; a cycle model of the sequencing rules is compared every cycle,
// and directed scenarios check hand-computed timing and status values.
module tb_python_align_ctrl;

    localparam int RC = 8;
    localparam int TO = 64;
    localparam int MR = 3;

    localparam int M_IDLE   = 0;
    localparam int M_RESET  = 1;
    localparam int M_WAIT   = 2;
    localparam int M_LOCKED = 3;
    localparam int M_FAIL   = 4;

    typedef struct {
        int st;
        int tcnt;
        int retries;
        bit lost;
    } mdl_t;

    logic clk = 1'b0;
    logic reset, start, stop, done, err;

    logic       ar0, busy0, locked0, failed0, lost0;
    logic [1:0] rc0;
    logic [2:0] st0;
    logic       ar1, busy1, locked1, failed1, lost1;
    logic [1:0] rc1;
    logic [2:0] st1;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    mdl_t m0 = '{M_IDLE, 0, 0, 1'b0};
    mdl_t m1 = '{M_IDLE, 0, 0, 1'b0};

    always #5 clk = ~clk;

    python_align_ctrl #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR), .AUTO_RELOCK(1)) dut0 (
        .reset(reset), .clk(clk), .start(start), .stop(stop),
        .align_reset(ar0), .align_done(done), .align_error(err),
        .busy(busy0), .locked(locked0), .failed(failed0), .lock_lost(lost0),
        .retry_count(rc0), .state(st0)
    );

    python_align_ctrl #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR), .AUTO_RELOCK(0)) dut1 (
        .reset(reset), .clk(clk), .start(start), .stop(stop),
        .align_reset(ar1), .align_done(done), .align_error(err),
        .busy(busy1), .locked(locked1), .failed(failed1), .lock_lost(lost1),
        .retry_count(rc1), .state(st1)
    );

    // One clock of the sequencing rules, tracking time spent in the current phase.
    function automatic mdl_t mstep(mdl_t m, bit rst, bit st, bit sp, bit dn, bit er, bit arl);
        mdl_t n;
        bit   fail;
        n    = m;
        fail = 1'b0;
        if (rst) begin
            n = '{M_IDLE, 0, 0, 1'b0};
            return n;
        end
        if (sp) begin
            n.st   = M_IDLE;
            n.tcnt = 0;
            return n;
        end
        if (st) begin
            n = '{M_RESET, 0, 0, 1'b0};
            return n;
        end
        n.tcnt = m.tcnt + 1;
        case (m.st)
            M_RESET: if (n.tcnt == RC) begin
                n.st   = M_WAIT;
                n.tcnt = 0;
            end
            M_WAIT: begin
                if (er) fail = 1'b1;
                else if (dn) begin
                    n.st   = M_LOCKED;
                    n.tcnt = 0;
                end else if (n.tcnt == TO) fail = 1'b1;
            end
            M_LOCKED: if (!dn) begin
                n.lost = 1'b1;
                n.tcnt = 0;
                if (arl) begin
                    n.st      = M_RESET;
                    n.retries = 0;
                end else begin
                    n.st = M_IDLE;
                end
            end
            default: ;
        endcase
        if (fail) begin
            n.tcnt = 0;
            if (m.retries == MR) n.st = M_FAIL;
            else begin
                n.retries = m.retries + 1;
                n.st      = M_RESET;
            end
        end
        return n;
    endfunction

    // Expected {align_reset, busy, locked, failed, lock_lost, retry_count, state}.
    function automatic logic [9:0] mexp(mdl_t m);
        logic [9:0] v;
        v[9]   = (m.st == M_IDLE) || (m.st == M_RESET) || (m.st == M_FAIL);
        v[8]   = (m.st == M_RESET) || (m.st == M_WAIT);
        v[7]   = (m.st == M_LOCKED);
        v[6]   = (m.st == M_FAIL);
        v[5]   = m.lost;
        v[4:3] = 2'(m.retries);
        v[2:0] = 3'(m.st);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        m0 <= mstep(m0, reset, start, stop, done, err, 1'b1);
        m1 <= mstep(m1, reset, start, stop, done, err, 1'b0);
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_dut0", 32'({ar0, busy0, locked0, failed0, lost0, rc0, st0}), 32'(mexp(m0)));
            chk("model_dut1", 32'({ar1, busy1, locked1, failed1, lost1, rc1, st1}), 32'(mexp(m1)));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_until(input logic [2:0] code, input int budget, input string name);
        int n;
        n = 0;
        while (st0 != code && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(st0), 32'(code));
    endtask

    task automatic count_while(input logic [2:0] code, input int budget, output int n);
        n = 0;
        while (st0 == code && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; stop = 1'b0; done = 1'b0; err = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        reset  = 1'b0;
        chk("rst_state", 32'(st0), 32'd0);
        chk("rst_align_reset", 32'(ar0), 32'd1);
        chk("rst_status", 32'({busy0, locked0, failed0, lost0, rc0}), 32'd0);

        // Nominal lock.
        pulse_start();
        count_while(3'd1, 50, n);
        chk("t1_reset_len", 32'(n), 32'd8);
        chk("t1_align_reset_low", 32'({ar0, st0}), 32'({1'b0, 3'd2}));
        repeat (20) tick();
        done = 1'b1;
        tick();
        chk("t1_locked", 32'({locked0, rc0, st0}), 32'({1'b1, 2'd0, 3'd3}));

        // Lock loss: auto-relock instance restarts, the other drops to IDLE.
        done = 1'b0;
        tick();
        chk("t4_auto_state", 32'({lost0, rc0, st0}), 32'({1'b1, 2'd0, 3'd1}));
        chk("t4_noauto_state", 32'({lost1, ar1, st1}), 32'({1'b1, 1'b1, 3'd0}));
        wait_until(3'd2, 50, "t4_rewait");
        done = 1'b1;
        tick();
        chk("t4_relock_sticky", 32'({locked0, lost0}), 32'({1'b1, 1'b1}));
        done  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_start_clears", 32'({lost0, lost1, st0}), 32'({1'b0, 1'b0, 3'd1}));

        // Two error attempts, then lock on the third.
        for (int k = 0; k < 2; k++) begin
            wait_until(3'd2, 50, "t2_wait");
            err = 1'b1;
            tick();
            err = 1'b0;
            chk("t2_retry", 32'({rc0, st0}), 32'({2'(k + 1), 3'd1}));
            count_while(3'd1, 50, n);
            chk("t2_retry_reset_len", 32'(n), 32'd8);
        end
        done = 1'b1;
        tick();
        chk("t2_locked", 32'({locked0, rc0, st0}), 32'({1'b1, 2'd2, 3'd3}));

        // Done and error together count as a failure; start+stop goes IDLE.
        done = 1'b0;
        pulse_start();
        wait_until(3'd2, 50, "t5_wait");
        done = 1'b1;
        err  = 1'b1;
        tick();
        done = 1'b0;
        err  = 1'b0;
        chk("t5_both_fail", 32'({rc0, st0}), 32'({2'd1, 3'd1}));
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_start_stop", 32'({ar0, busy0, st0}), 32'({1'b1, 1'b0, 3'd0}));

        // Silent aligner: 4 attempts of 8 + 64 cycles, then FAIL.
        pulse_start();
        n = 0;
        while (st0 != 3'd4 && n < 400) begin
            tick();
            n++;
        end
        chk("t3_cycles_to_fail", 32'(n), 32'd288);
        chk("t3_fail_status", 32'({failed0, ar0, rc0, st0}), 32'({1'b1, 1'b1, 2'd3, 3'd4}));
        repeat (10) tick();
        chk("t3_fail_hold", 32'(st0), 32'd4);
        pulse_start();
        chk("t3_restart", 32'({failed0, rc0, st0}), 32'({1'b0, 2'd0, 3'd1}));

        // Reset in the middle of WAIT.
        wait_until(3'd2, 50, "t6_wait");
        repeat (30) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_reset_values", 32'({ar0, busy0, locked0, failed0, lost0, rc0, st0}), 32'({1'b1, 6'd0, 3'd0}));
        pulse_start();
        count_while(3'd1, 50, n);
        chk("t6_fresh_reset_len", 32'(n), 32'd8);

        // Stop out of LOCKED is not a lock loss.
        done = 1'b1;
        tick();
        chk("t7_locked", 32'(st0), 32'd3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t7_stop", 32'({lost0, ar0, st0}), 32'({1'b0, 1'b1, 3'd0}));
        done = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
